// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and defaults for the memory controller slice.
// Holds the FSM state encoding, the default word/address sizes, the default
// write-protection limit and the wait-counter load helper.
package mem_ctrl_pkg;

    // Default data word width of the accumulator CPU
    localparam int WORDSIZE       = 16;
    // Default word-address width; RAM depth is 2**ADDRSIZE words
    localparam int ADDRSIZE       = 8;
    // Addresses below this are write-protected when protection is built in
    localparam int DEF_PROT_LIMIT = 96;
    // Width of the wait-state down-counter (0..15 wait states)
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_WAIT   = 2'd1,
        MC_ACCESS = 2'd2,
        MC_ACK    = 2'd3
    } mc_state_t;

    // Value loaded into the wait counter on accept: the WAIT state exits
    // when the counter reaches zero, so it starts at cycles-1.
    function automatic logic [CNT_W-1:0] wait_load(input int cycles);
        if (cycles > 0) begin
            return CNT_W'(cycles - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, read-first, with a registered
// read port. Kept as its own module so it can be replaced by a vendor
// macro with the same port list. Contents are not reset.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port and registered read-first read port share one address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d_in;
        end
        d_out <= mem[addr];
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: request/ack memory controller in front of the on-chip RAM.
// A hello request is latched in IDLE, optionally delayed by WAIT_CYCLES
// wait states, serviced in a single ACCESS cycle and acknowledged with a
// four-phase ack that is held until hello drops.
// Optional feature: define MEM_CTRL_WPROT_EN to drop writes to addresses
// below PROT_LIMIT and flag them on mem_wp_err_o.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = WORDSIZE,
    parameter int ADDR_W      = ADDRSIZE,
    parameter int WAIT_CYCLES = 2,
    parameter int PROT_LIMIT  = DEF_PROT_LIMIT
) (
    input  logic              mem_clk_i,
    input  logic              mem_rst_n_i,
    input  logic              mem_hello_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_busy_o,
    output logic              mem_wp_err_o
);

    // Parameter sanity: the wait counter is 4 bits wide and the protection
    // limit must lie inside the backed address range.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_ctrl: WAIT_CYCLES must be in 0..15");
    end
    if (PROT_LIMIT < 0 || PROT_LIMIT > (2**ADDR_W)) begin : g_bad_prot
        $error("mem_ctrl: PROT_LIMIT outside the address range");
    end

    mc_state_t         state;
    mc_state_t         state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic              ack;
    logic              busy;
    logic              wp_err;
    logic [DATA_W-1:0] rd_data;

    logic              ack_nx;
    logic              busy_nx;
    logic              wp_err_nx;
    logic              rd_load;

    logic              accept;
    logic              prot_hit;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;

    assign accept = (state == MC_IDLE) && mem_hello_i;

    // The RAM is addressed straight from the bus while idle so that the
    // read-first output already holds RAM[addr] by the ACCESS cycle, even
    // with zero wait states. Afterwards the latched address is used.
    assign ram_addr = (state == MC_IDLE) ? mem_addr_i : req_addr;

`ifdef MEM_CTRL_WPROT_EN
    // Writes into the low region (exception vectors) are dropped
    assign prot_hit = req_we && (int'(req_addr) < PROT_LIMIT);
`else
    assign prot_hit = 1'b0;
`endif

    mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (mem_clk_i),
        .we   (ram_we),
        .addr (ram_addr),
        .d_in (req_data),
        .d_out(ram_q)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge mem_clk_i) begin
        if (!mem_rst_n_i) begin
            state <= MC_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Wait-state counter with synchronous active-low reset
    always_ff @(posedge mem_clk_i) begin
        if (!mem_rst_n_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nx;
        end
    end

    // Request registers capture the bundle on accept; no reset needed
    always_ff @(posedge mem_clk_i) begin
        if (accept) begin
            req_we   <= mem_we_i;
            req_addr <= mem_addr_i;
            req_data <= mem_data_i;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            MC_IDLE: begin
                if (mem_hello_i) begin
                    cnt_nx = wait_load(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_nx = MC_WAIT;
                    end else begin
                        state_nx = MC_ACCESS;
                    end
                end
            end
            MC_WAIT: begin
                if (cnt == '0) begin
                    state_nx = MC_ACCESS;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            MC_ACCESS: begin
                state_nx = MC_ACK;
            end
            MC_ACK: begin
                // hello still high keeps us here: one access per request
                if (!mem_hello_i) begin
                    state_nx = MC_IDLE;
                end
            end
            default: begin
                state_nx = MC_IDLE;
            end
        endcase
    end

    // Output decode: next values of the registered outputs and RAM strobes
    always_comb begin
        ack_nx    = ack;
        busy_nx   = (state_nx != MC_IDLE);
        wp_err_nx = 1'b0;
        rd_load   = 1'b0;
        ram_we    = 1'b0;
        unique case (state)
            MC_ACCESS: begin
                ack_nx = 1'b1;
                if (req_we) begin
                    if (prot_hit) begin
                        wp_err_nx = 1'b1;
                    end else begin
                        // a reset on the same edge wins and drops the write
                        ram_we = mem_rst_n_i;
                    end
                end else begin
                    rd_load = 1'b1;
                end
            end
            MC_ACK: begin
                if (!mem_hello_i) begin
                    ack_nx = 1'b0;
                end
            end
            default: begin
                ack_nx = 1'b0;
            end
        endcase
    end

    // Registered outputs; read data only changes on a read ACCESS
    always_ff @(posedge mem_clk_i) begin
        if (!mem_rst_n_i) begin
            ack     <= 1'b0;
            busy    <= 1'b0;
            wp_err  <= 1'b0;
            rd_data <= '0;
        end else begin
            ack    <= ack_nx;
            busy   <= busy_nx;
            wp_err <= wp_err_nx;
            if (rd_load) begin
                rd_data <= ram_q;
            end
        end
    end

    assign mem_ack_o    = ack;
    assign mem_busy_o   = busy;
    assign mem_wp_err_o = wp_err;
    assign mem_data_o   = rd_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. Two instances share clock
// and reset: dut 0 with two wait states, dut 1 with none. A directed vector
// table, hand-written corner sequences and randomized transactions are all
// checked against an array model of RAM built from the transaction rules.
module tb_mem_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int WC0  = 2;
    localparam int WC1  = 0;
    localparam int PLIM = 96;
`ifdef MEM_CTRL_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hello [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          ack   [2];
    logic [DW-1:0] rdata [2];
    logic          busy  [2];
    logic          wperr [2];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem_m [2][2**AW];
    logic [DW-1:0] last_rd [2];

    always #5 clk = ~clk;

    mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC0), .PROT_LIMIT(PLIM)) dut0 (
        .mem_clk_i(clk), .mem_rst_n_i(rst_n), .mem_hello_i(hello[0]), .mem_we_i(we[0]),
        .mem_addr_i(addr[0]), .mem_data_i(wdata[0]), .mem_ack_o(ack[0]),
        .mem_data_o(rdata[0]), .mem_busy_o(busy[0]), .mem_wp_err_o(wperr[0])
    );

    mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC1), .PROT_LIMIT(PLIM)) dut1 (
        .mem_clk_i(clk), .mem_rst_n_i(rst_n), .mem_hello_i(hello[1]), .mem_we_i(we[1]),
        .mem_addr_i(addr[1]), .mem_data_i(wdata[1]), .mem_ack_o(ack[1]),
        .mem_data_o(rdata[1]), .mem_busy_o(busy[1]), .mem_wp_err_o(wperr[1])
    );

    function automatic int wc_of(input int d);
        return (d == 0) ? WC0 : WC1;
    endfunction

    function automatic bit is_prot(input bit w, input logic [AW-1:0] a);
        return WPROT && w && (int'(a) < PLIM);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model update for a completed transaction
    task automatic model_apply(input int d, input bit w, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd);
        if (w && !is_prot(w, a)) begin
            mem_m[d][a] = wd;
        end
    endtask

    // One full four-phase transaction. lat counts edges after the accept
    // edge until ack is seen; edges counts accept..release inclusive.
    task automatic do_txn(input int d, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int hold,
                          output logic [DW-1:0] rd, output int lat,
                          output int edges, output int errs);
        bit done;
        @(negedge clk);
        hello[d] = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        lat = -1; edges = 0; errs = 0; done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            edges++;
            if (wperr[d]) errs++;
            if (ack[d]) begin
                lat  = k - 1;
                done = 1'b1;
            end else if (k >= 2) begin
                check("busy_in_wait", busy[d], 1);
            end
            // inputs are ignored after accept
            if (k == 1) begin
                we[d]    = ~w;
                addr[d]  = AW'($urandom);
                wdata[d] = DW'($urandom);
            end
        end
        if (!done) check("ack_timeout", 0, 1);
        rd = rdata[d];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            edges++;
            if (wperr[d]) errs++;
            check("ack_held", ack[d], 1);
            check("data_held", rdata[d], rd);
            check("busy_held", busy[d], 1);
        end
        @(negedge clk);
        hello[d] = 1'b0;
        @(posedge clk); #1;
        edges++;
        if (wperr[d]) errs++;
        check("ack_release", ack[d], 0);
        check("busy_release", busy[d], 0);
    endtask

    // Transaction plus every check derived from the model
    task automatic txn_checked(input string tag, input int d, input bit w,
                               input logic [AW-1:0] a, input logic [DW-1:0] wd, input int hold);
        logic [DW-1:0] rd;
        int lat, edges, errs;
        logic [DW-1:0] exp_rd;
        exp_rd = w ? last_rd[d] : mem_m[d][a];
        do_txn(d, w, a, wd, hold, rd, lat, edges, errs);
        check({tag, "_lat"}, lat, wc_of(d) + 1);
        check({tag, "_edges"}, edges, wc_of(d) + 3 + hold);
        check({tag, "_data"}, rd, exp_rd);
        check({tag, "_wperr"}, errs, is_prot(w, a));
        model_apply(d, w, a, wd);
        last_rd[d] = exp_rd;
    endtask

    typedef struct {
        int            d;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        bit            chk;
        logic [DW-1:0] exp_rd;
        int            exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [DW-1:0] rd;
        int lat, edges, errs;
        bit done;

        for (int d = 0; d < 2; d++) begin
            hello[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            last_rd[d] = '0;
            for (int i = 0; i < 2**AW; i++) mem_m[d][i] = '0;
        end

        tbl[0] = '{0, 1'b0, 8'd5,  16'h0000, 1'b1, 16'h0000, 0};
        tbl[1] = '{0, 1'b1, 8'd10, 16'h1234, 1'b0, 16'h0000, 0};
        tbl[2] = '{0, 1'b0, 8'd10, 16'h0000, 1'b1, 16'h1234, 0};
        tbl[3] = '{0, 1'b1, 8'd64, 16'hFFFF, 1'b0, 16'h0000, int'(WPROT)};
        tbl[4] = '{0, 1'b0, 8'd64, 16'h0000, 1'b1, WPROT ? 16'h0000 : 16'hFFFF, 0};
        tbl[5] = '{1, 1'b0, 8'd7,  16'h0000, 1'b1, 16'h0000, 0};
        tbl[6] = '{1, 1'b1, 8'd7,  16'hA5A5, 1'b0, 16'h0000, 0};
        tbl[7] = '{1, 1'b0, 8'd7,  16'h0000, 1'b1, 16'hA5A5, 0};
        tbl[8] = '{0, 1'b1, 8'd20, 16'h1111, 1'b0, 16'h0000, 0};
        tbl[9] = '{1, 1'b1, 8'd100, 16'h0999, 1'b0, 16'h0000, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ack", ack[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_data", rdata[d], 0);
            check("rst_wperr", wperr[d], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] prev;
            prev = last_rd[tbl[i].d];
            do_txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, 0, rd, lat, edges, errs);
            check($sformatf("vec%0d_lat", i), lat, wc_of(tbl[i].d) + 1);
            check($sformatf("vec%0d_edges", i), edges, wc_of(tbl[i].d) + 3);
            check($sformatf("vec%0d_wperr", i), errs, tbl[i].exp_err);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
                last_rd[tbl[i].d] = tbl[i].exp_rd;
            end else begin
                check($sformatf("vec%0d_keep", i), rd, prev);
            end
            model_apply(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd);
        end

        // hello held long after ack: ack and data stable, single access
        txn_checked("hold_wr", 0, 1'b1, 8'd40, 16'h4242, 10);
        txn_checked("hold_rd", 0, 1'b0, 8'd40, 16'h0000, 10);

        // reset during WAIT of a write: dropped, ack never rises
        @(negedge clk);
        hello[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'd20; wdata[0] = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstwait_ack", ack[0], 0);
        check("rstwait_busy", busy[0], 0);
        check("rstwait_data0", rdata[0], 0);
        check("rstwait_data1", rdata[1], 0);
        check("rstwait_ack1", ack[1], 0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        hello[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rstwait_noack", ack[0], 0);
        end
        txn_checked("rstwait_rd", 0, 1'b0, 8'd20, 16'h0000, 0);

        // reset on the very edge of a zero-wait ACCESS write: reset wins
        @(negedge clk);
        hello[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'd100; wdata[1] = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstacc_ack", ack[1], 0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        hello[1] = 1'b0;
        txn_checked("rstacc_rd", 1, 1'b0, 8'd100, 16'h0000, 0);

        // hello dropped early: request completes, ack shown then cleared
        @(negedge clk);
        hello[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd10;
        @(posedge clk);
        @(negedge clk);
        hello[0] = 1'b0;
        done = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(posedge clk); #1;
            if (ack[0]) begin
                lat = k;
                done = 1'b1;
            end
        end
        check("early_lat", lat, WC0 + 1);
        check("early_data", rdata[0], mem_m[0][10]);
        last_rd[0] = mem_m[0][10];
        @(posedge clk); #1;
        check("early_ackclr", ack[0], 0);
        check("early_busyclr", busy[0], 0);

        // zero-wait back-to-back read/write/read
        txn_checked("b2b_rd0", 1, 1'b0, 8'd33, 16'h0000, 0);
        txn_checked("b2b_wr", 1, 1'b1, 8'd33, 16'hC0DE, 0);
        txn_checked("b2b_rd1", 1, 1'b0, 8'd33, 16'h0000, 0);

        // randomized traffic against the array model
        for (int n = 0; n < 200; n++) begin
            int d;
            bit w;
            logic [AW-1:0] a;
            d = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = (n % 4 == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 255));
            txn_checked("rand", d, w, a, DW'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
